// File: rtl/alien_march_ctrl.sv
// Alien formation sequencer: paces steps from frame ticks, scans the alive grid, moves the formation.
// Optional alien fire requests are built when the ALIEN_FIRE_EN macro is defined.
module alien_march_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int COL_PITCH   = 32,
  parameter int ROW_PITCH   = 24,
  parameter int ALIEN_W     = 24,
  parameter int ALIEN_H     = 16,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 16,
  parameter int START_X     = 64,
  parameter int START_Y     = 48,
  parameter int INVADE_Y    = 400,
  parameter int BASE_PERIOD = 30,
  parameter int MIN_PERIOD  = 2,
  parameter int SPEEDUP     = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            run,
  input  logic [9:0][5:0] alien_grid,
  input  logic [5:0]      count,
  output logic [9:0]      formation_x,
  output logic [9:0]      formation_y,
  output logic            dir_left,
  output logic            anim_frame,
  output logic            step_pulse,
  output logic            wave_clear,
  output logic            invaded,
  output logic            fire_req,
  output logic [3:0]      fire_col,
  output logic [2:0]      fire_row,
  input  logic            fire_ack
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  state_t            state;
  logic signed [10:0] period_raw;
  logic [10:0]       period;
  logic [10:0]       div_cnt;
  logic              halted;
  logic              tick_en;
  logic              expiry;
  logic              pending;
  logic [9:0][5:0]   snap;
  logic [3:0]        scan_col;
  logic [3:0]        colmin;
  logic [3:0]        colmax;
  logic [2:0]        rowmax;
  logic              any;
  logic [5:0]        col_bits;
  logic [2:0]        col_top;
  logic [10:0]       fx;
  logic [10:0]       right_edge;
  logic [10:0]       left_edge;
  logic [10:0]       down_y;
  logic [10:0]       bottom;
  logic              hit_edge;

  function automatic logic [2:0] top_row(input logic [5:0] bits);
    top_row = 3'd0;
    for (int i = 0; i < 6; i++)
      if (bits[i]) top_row = 3'(i);
  endfunction

  // Faster marching as kills accumulate; the signed form lets large counts saturate cleanly.
  assign period_raw = $signed(11'(BASE_PERIOD)) - $signed({5'd0, count}) * $signed(11'(SPEEDUP));
  assign period     = (period_raw < $signed(11'(MIN_PERIOD))) ? 11'(MIN_PERIOD) : $unsigned(period_raw);

  assign halted  = wave_clear | invaded;
  assign tick_en = frame_tick & run & ~halted;
  assign expiry  = tick_en & (div_cnt <= 11'd1);

  assign col_bits = snap[scan_col];
  assign col_top  = top_row(col_bits);

  assign fx         = {1'b0, formation_x};
  assign right_edge = fx + 11'(colmax) * 11'(COL_PITCH) + 11'(ALIEN_W + STEP_X);
  assign left_edge  = fx + 11'(colmin) * 11'(COL_PITCH);
  assign hit_edge   = dir_left ? (left_edge < 11'(STEP_X)) : (right_edge > 11'(SCREEN_W - 1));
  assign down_y     = {1'b0, formation_y} + 11'(STEP_Y);
  assign bottom     = down_y + 11'(rowmax) * 11'(ROW_PITCH) + 11'(ALIEN_H);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      div_cnt     <= period;
      pending     <= 1'b0;
      snap        <= '0;
      scan_col    <= 4'd0;
      colmin      <= 4'd9;
      colmax      <= 4'd0;
      rowmax      <= 3'd0;
      any         <= 1'b0;
      formation_x <= 10'(START_X);
      formation_y <= 10'(START_Y);
      dir_left    <= 1'b0;
      anim_frame  <= 1'b0;
      step_pulse  <= 1'b0;
      wave_clear  <= 1'b0;
      invaded     <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (tick_en) div_cnt <= expiry ? period : div_cnt - 11'd1;
      case (state)
        IDLE: begin
          if ((expiry || pending) && !halted) begin
            state    <= SCAN;
            snap     <= alien_grid;
            scan_col <= 4'd0;
            colmin   <= 4'd9;
            colmax   <= 4'd0;
            rowmax   <= 3'd0;
            any      <= 1'b0;
            pending  <= 1'b0;
          end
        end
        SCAN: begin
          if (expiry) pending <= 1'b1;
          if (|col_bits) begin
            if (scan_col < colmin) colmin <= scan_col;
            if (scan_col > colmax) colmax <= scan_col;
            if (col_top > rowmax) rowmax <= col_top;
            any <= 1'b1;
          end
          if (scan_col == 4'd9) state <= DECIDE;
          else scan_col <= scan_col + 4'd1;
        end
        DECIDE: begin
          state <= IDLE;
          if (expiry) pending <= 1'b1;
          if (!any) begin
            wave_clear <= 1'b1;
          end else begin
            step_pulse <= 1'b1;
            anim_frame <= ~anim_frame;
            if (hit_edge) begin
              formation_y <= down_y[9:0];
              dir_left    <= ~dir_left;
              if (bottom >= 11'(INVADE_Y)) invaded <= 1'b1;
            end else if (dir_left) begin
              formation_x <= formation_x - 10'(STEP_X);
            end else begin
              formation_x <= formation_x + 10'(STEP_X);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALIEN_FIRE_EN
  logic [7:0] lfsr;
  logic [3:0] cand;
  logic [5:0] cand_bits;

  assign cand      = 4'(lfsr % 8'd10);
  assign cand_bits = snap[cand];

  // A pending shot is never replaced; a new one is only drawn once the old one is acknowledged.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr     <= 8'hA5;
      fire_req <= 1'b0;
      fire_col <= 4'd0;
      fire_row <= 3'd0;
    end else begin
      if (step_pulse) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (fire_req) begin
        if (fire_ack) fire_req <= 1'b0;
      end else if (state == DECIDE && |cand_bits) begin
        fire_req <= 1'b1;
        fire_col <= cand;
        fire_row <= top_row(cand_bits);
      end
    end
  end
`else
  logic unused_fire_ack;

  assign unused_fire_ack = fire_ack;
  assign fire_req        = 1'b0;
  assign fire_col        = 4'd0;
  assign fire_row        = 3'd0;
`endif

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed self-checking bench for alien_march_ctrl: reset, pacing, edges, wave clear, invasion, fire.
module tb_alien_march_ctrl;

  logic            Clk;
  logic            Reset;
  logic            frame_tick;
  logic            run;
  logic [9:0][5:0] alien_grid;
  logic [5:0]      count;
  logic [9:0]      formation_x;
  logic [9:0]      formation_y;
  logic            dir_left;
  logic            anim_frame;
  logic            step_pulse;
  logic            wave_clear;
  logic            invaded;
  logic            fire_req;
  logic [3:0]      fire_col;
  logic [2:0]      fire_row;
  logic            fire_ack;

  int compared;
  int mismatched;

  alien_march_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .run(run),
    .alien_grid(alien_grid), .count(count),
    .formation_x(formation_x), .formation_y(formation_y), .dir_left(dir_left),
    .anim_frame(anim_frame), .step_pulse(step_pulse), .wave_clear(wave_clear),
    .invaded(invaded), .fire_req(fire_req), .fire_col(fire_col), .fire_row(fire_row),
    .fire_ack(fire_ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic apply_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
  endtask

  // Two back-to-back ticks expire a period-2 divider once, then wait for the step to land.
  task automatic do_step(output bit got);
    got = 1'b0;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge Clk); #1;
      if (step_pulse) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Spaced single ticks; reports which tick number produced the first step.
  task automatic ticks_until_step(input int max_ticks, output int n);
    n = 0;
    for (int t = 1; t <= max_ticks && n == 0; t++) begin
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0;
      for (int i = 0; i < 14; i++) begin
        if (step_pulse && n == 0) n = t;
        @(posedge Clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    compared += 8;
    if (formation_x !== 10'd64) begin mismatched++; $display("[TB] FAIL reset_x: got %0d expected 64", formation_x); end
    if (formation_y !== 10'd48) begin mismatched++; $display("[TB] FAIL reset_y: got %0d expected 48", formation_y); end
    if (dir_left !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dir: got %0b expected 0", dir_left); end
    if (anim_frame !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_anim: got %0b expected 0", anim_frame); end
    if (step_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_step: got %0b expected 0", step_pulse); end
    if (wave_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wave: got %0b expected 0", wave_clear); end
    if (invaded !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_invaded: got %0b expected 0", invaded); end
    if (fire_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fire_req: got %0b expected 0", fire_req); end
  endtask

  task automatic test_first_step();
    int early;
    early = 0;
    for (int i = 0; i < 30; i++) begin
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      if (step_pulse) early++;
    end
    frame_tick = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      if (step_pulse) early++;
    end
    @(posedge Clk); #1;
    compared += 5;
    if (early !== 0) begin mismatched++; $display("[TB] FAIL first_step_early: got %0d early pulses expected 0", early); end
    if (step_pulse !== 1'b1) begin mismatched++; $display("[TB] FAIL first_step_pulse: got %0b expected 1", step_pulse); end
    if (formation_x !== 10'd68) begin mismatched++; $display("[TB] FAIL first_step_x: got %0d expected 68", formation_x); end
    if (anim_frame !== 1'b1) begin mismatched++; $display("[TB] FAIL first_step_anim: got %0b expected 1", anim_frame); end
    if (formation_y !== 10'd48) begin mismatched++; $display("[TB] FAIL first_step_y: got %0d expected 48", formation_y); end
    @(posedge Clk); #1;
    compared++;
    if (step_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL first_step_single: got %0b expected 0", step_pulse); end
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    for (int i = 0; i < 30; i++) begin
      frame_tick = 1'b1;
      @(posedge Clk); #1;
    end
    frame_tick = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    compared += 4;
    if (formation_x !== 10'd64) begin mismatched++; $display("[TB] FAIL midscan_x: got %0d expected 64", formation_x); end
    if (formation_y !== 10'd48) begin mismatched++; $display("[TB] FAIL midscan_y: got %0d expected 48", formation_y); end
    if (dir_left !== 1'b0) begin mismatched++; $display("[TB] FAIL midscan_dir: got %0b expected 0", dir_left); end
    if (anim_frame !== 1'b0) begin mismatched++; $display("[TB] FAIL midscan_anim: got %0b expected 0", anim_frame); end
    #2;
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk); #1;
      if (step_pulse) pulses++;
    end
    compared++;
    if (pulses !== 0) begin mismatched++; $display("[TB] FAIL midscan_no_step: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_period();
    int n;
    count = 6'd40;
    apply_reset();
    ticks_until_step(40, n);
    compared++;
    if (n !== 2) begin mismatched++; $display("[TB] FAIL period_40_first: got tick %0d expected 2", n); end
    ticks_until_step(40, n);
    compared++;
    if (n !== 2) begin mismatched++; $display("[TB] FAIL period_40_second: got tick %0d expected 2", n); end
    count = 6'd10;
    apply_reset();
    ticks_until_step(40, n);
    compared++;
    if (n !== 20) begin mismatched++; $display("[TB] FAIL period_10: got tick %0d expected 20", n); end
  endtask

  task automatic test_run_gate();
    bit got;
    count = 6'd60;
    apply_reset();
    run = 1'b0;
    do_step(got);
    compared++;
    if (got !== 1'b0) begin mismatched++; $display("[TB] FAIL run_gate_frozen: got step %0b expected 0", got); end
    run = 1'b1;
    do_step(got);
    compared += 2;
    if (got !== 1'b1) begin mismatched++; $display("[TB] FAIL run_gate_resume: got step %0b expected 1", got); end
    if (formation_x !== 10'd68) begin mismatched++; $display("[TB] FAIL run_gate_x: got %0d expected 68", formation_x); end
  endtask

  task automatic test_march_right();
    bit got;
    int missed;
    logic [9:0] x65, y65, x66, y66, x67, y67;
    logic d65, d66, d67;
    count = 6'd60;
    alien_grid = '1;
    apply_reset();
    missed = 0;
    for (int s = 1; s <= 67; s++) begin
      do_step(got);
      if (!got) missed++;
      if (s == 65) begin x65 = formation_x; y65 = formation_y; d65 = dir_left; end
      if (s == 66) begin x66 = formation_x; y66 = formation_y; d66 = dir_left; end
      if (s == 67) begin x67 = formation_x; y67 = formation_y; d67 = dir_left; end
    end
    compared += 11;
    if (missed !== 0) begin mismatched++; $display("[TB] FAIL march_missed: got %0d missing steps expected 0", missed); end
    if (x65 !== 10'd324) begin mismatched++; $display("[TB] FAIL march_x65: got %0d expected 324", x65); end
    if (y65 !== 10'd48) begin mismatched++; $display("[TB] FAIL march_y65: got %0d expected 48", y65); end
    if (d65 !== 1'b0) begin mismatched++; $display("[TB] FAIL march_dir65: got %0b expected 0", d65); end
    if (x66 !== 10'd324) begin mismatched++; $display("[TB] FAIL march_x66: got %0d expected 324", x66); end
    if (y66 !== 10'd64) begin mismatched++; $display("[TB] FAIL march_y66: got %0d expected 64", y66); end
    if (d66 !== 1'b1) begin mismatched++; $display("[TB] FAIL march_dir66: got %0b expected 1", d66); end
    if (x67 !== 10'd320) begin mismatched++; $display("[TB] FAIL march_x67: got %0d expected 320", x67); end
    if (y67 !== 10'd64) begin mismatched++; $display("[TB] FAIL march_y67: got %0d expected 64", y67); end
    if (d67 !== 1'b1) begin mismatched++; $display("[TB] FAIL march_dir67: got %0b expected 1", d67); end
    if (anim_frame !== 1'b1) begin mismatched++; $display("[TB] FAIL march_anim: got %0b expected 1", anim_frame); end
  endtask

  task automatic test_left_edge_and_clear();
    bit got;
    bit found;
    count = 6'd60;
    alien_grid = '0;
    alien_grid[0] = 6'h3F;
    apply_reset();
    found = 1'b0;
    for (int s = 0; s < 400 && !found; s++) begin
      do_step(got);
      if (formation_x == 10'd4 && dir_left) found = 1'b1;
    end
    compared++;
    if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL left_reach_x4: got %0b expected 1", found); end
    do_step(got);
    compared += 4;
    if (got !== 1'b1) begin mismatched++; $display("[TB] FAIL left_step_to0: got step %0b expected 1", got); end
    if (formation_x !== 10'd0) begin mismatched++; $display("[TB] FAIL left_x0: got %0d expected 0", formation_x); end
    if (formation_y !== 10'd64) begin mismatched++; $display("[TB] FAIL left_y_before_down: got %0d expected 64", formation_y); end
    if (dir_left !== 1'b1) begin mismatched++; $display("[TB] FAIL left_dir_before_down: got %0b expected 1", dir_left); end
    do_step(got);
    compared += 3;
    if (formation_x !== 10'd0) begin mismatched++; $display("[TB] FAIL left_down_x: got %0d expected 0", formation_x); end
    if (formation_y !== 10'd80) begin mismatched++; $display("[TB] FAIL left_down_y: got %0d expected 80", formation_y); end
    if (dir_left !== 1'b0) begin mismatched++; $display("[TB] FAIL left_down_dir: got %0b expected 0", dir_left); end
    alien_grid = '0;
    do_step(got);
    compared += 4;
    if (got !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_no_step: got step %0b expected 0", got); end
    if (wave_clear !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_flag: got %0b expected 1", wave_clear); end
    if (formation_x !== 10'd0) begin mismatched++; $display("[TB] FAIL clear_x: got %0d expected 0", formation_x); end
    if (formation_y !== 10'd80) begin mismatched++; $display("[TB] FAIL clear_y: got %0d expected 80", formation_y); end
    alien_grid = '1;
    do_step(got);
    compared += 2;
    if (got !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_frozen: got step %0b expected 0", got); end
    if (wave_clear !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_sticky: got %0b expected 1", wave_clear); end
  endtask

  // Row 5 alone: bottom = y + 5*24 + 16, so the first down step with y >= 264 (y = 272) invades.
  task automatic test_invasion();
    bit got;
    logic [9:0] prev_y;
    count = 6'd60;
    for (int c = 0; c < 10; c++) alien_grid[c] = 6'b100000;
    apply_reset();
    prev_y = formation_y;
    for (int s = 0; s < 1500 && !invaded; s++) begin
      prev_y = formation_y;
      do_step(got);
      if (!got) break;
    end
    compared += 3;
    if (invaded !== 1'b1) begin mismatched++; $display("[TB] FAIL invade_flag: got %0b expected 1", invaded); end
    if (formation_y !== 10'd272) begin mismatched++; $display("[TB] FAIL invade_y: got %0d expected 272", formation_y); end
    if (prev_y !== 10'd256) begin mismatched++; $display("[TB] FAIL invade_prev_y: got %0d expected 256", prev_y); end
    do_step(got);
    compared += 3;
    if (got !== 1'b0) begin mismatched++; $display("[TB] FAIL invade_frozen: got step %0b expected 0", got); end
    if (formation_y !== 10'd272) begin mismatched++; $display("[TB] FAIL invade_y_hold: got %0d expected 272", formation_y); end
    if (wave_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL invade_wave: got %0b expected 0", wave_clear); end
  endtask

  task automatic test_fire();
    bit got;
    count = 6'd60;
    alien_grid = '1;
    apply_reset();
`ifdef ALIEN_FIRE_EN
    do_step(got);
    compared += 3;
    if (fire_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fire_req1: got %0b expected 1", fire_req); end
    if (fire_col !== 4'd5) begin mismatched++; $display("[TB] FAIL fire_col1: got %0d expected 5", fire_col); end
    if (fire_row !== 3'd5) begin mismatched++; $display("[TB] FAIL fire_row1: got %0d expected 5", fire_row); end
    for (int s = 0; s < 2; s++) begin
      do_step(got);
      compared += 3;
      if (fire_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fire_hold_req: got %0b expected 1", fire_req); end
      if (fire_col !== 4'd5) begin mismatched++; $display("[TB] FAIL fire_hold_col: got %0d expected 5", fire_col); end
      if (fire_row !== 3'd5) begin mismatched++; $display("[TB] FAIL fire_hold_row: got %0d expected 5", fire_row); end
    end
    fire_ack = 1'b1;
    @(posedge Clk); #1;
    fire_ack = 1'b0;
    compared++;
    if (fire_req !== 1'b0) begin mismatched++; $display("[TB] FAIL fire_ack_clear: got %0b expected 0", fire_req); end
    do_step(got);
    compared += 3;
    if (fire_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fire_req4: got %0b expected 1", fire_req); end
    if (fire_col !== 4'd2) begin mismatched++; $display("[TB] FAIL fire_col4: got %0d expected 2", fire_col); end
    if (fire_row !== 3'd5) begin mismatched++; $display("[TB] FAIL fire_row4: got %0d expected 5", fire_row); end
`else
    for (int s = 0; s < 3; s++) begin
      do_step(got);
      compared += 3;
      if (fire_req !== 1'b0) begin mismatched++; $display("[TB] FAIL fire_off_req: got %0b expected 0", fire_req); end
      if (fire_col !== 4'd0) begin mismatched++; $display("[TB] FAIL fire_off_col: got %0d expected 0", fire_col); end
      if (fire_row !== 3'd0) begin mismatched++; $display("[TB] FAIL fire_off_row: got %0d expected 0", fire_row); end
    end
`endif
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset      = 1'b1;
    frame_tick = 1'b0;
    run        = 1'b1;
    alien_grid = '1;
    count      = 6'd0;
    fire_ack   = 1'b0;
    apply_reset();
    test_reset();
    test_first_step();
    test_reset_mid_scan();
    test_period();
    test_run_gate();
    test_march_right();
    test_left_edge_and_clear();
    test_invasion();
    test_fire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
